counter_ctrl: RTL and testbench

- Control front-end that sits directly upstream of the 4-bit up/down counter.
- Turns three raw push-buttons into the counter's control inputs: load, up_down, a count-enable tick and the parallel load value.
- Runs a small run/stop state machine that watches the counter's output and freezes counting at the terminal value instead of letting it wrap.

---
 rtl/counter_ctrl_pkg.sv | 22 ++
 rtl/counter_ctrl_btn_debounce.sv | 55 +++++
 rtl/counter_ctrl.sv | 115 +++++++++++
 tb/tb_counter_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter control front-end: FSM encoding,
// button indices and default parameter values.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int DIV_DEF   = 4;
  localparam int DEB_DEF   = 3;

  // Bit positions of the buttons inside the debouncer bank.
  localparam int BTN_LOAD = 0;
  localparam int BTN_DIR  = 1;
  localparam int BTN_RUN  = 2;
  localparam int NUM_BTN  = 3;

endpackage

// File: rtl/counter_ctrl_btn_debounce.sv
// One push-button path: 2-flop synchroniser, stable-level counter and a
// registered one-cycle press pulse on the debounced rising edge.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DEB = DEB_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          level_prev_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
      press_reg      <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Count consecutive samples that disagree with the accepted level;
      // any sample that agrees again restarts the count.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CW'(DEB - 1)) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
      level_prev_reg <= level_reg;
      press_reg      <= level_reg & ~level_prev_reg;
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/counter_ctrl.sv
// Control front-end for the up/down counter: debounced buttons, run/stop FSM,
// prescaler and registered counter control outputs.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV   = DIV_DEF,
  parameter int DEB   = DEB_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_load,
  input  logic             btn_dir,
  input  logic             btn_run,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic [WIDTH-1:0] d,
  output logic             up_down,
  output logic             en,
  output logic             tc,
  output logic [1:0]       state
);

  localparam int PW = $clog2(DIV);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] level_unused;

  assign raw = {btn_run, btn_dir, btn_load};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(.DEB(DEB)) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (raw[gi]),
        .level(level_unused[gi]),
        .press(press[gi])
      );
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             up_down_reg, up_down_next;
  logic             load_reg, en_reg, tc_reg;
  logic             en_next;
  logic             tick;
  logic             terminal;

  always_comb begin
    state_next   = state_reg;
    up_down_next = up_down_reg;
    en_next      = 1'b0;
    tick         = (presc_reg == PW'(DIV - 1));
    terminal     = up_down_reg ? (count == '1) : (count == '0);

    case (state_reg)
      IDLE, DONE: begin
        if (press[BTN_LOAD])      state_next = LOAD;
        else if (press[BTN_RUN])  state_next = RUN;
        else if (press[BTN_DIR])  up_down_next = ~up_down_reg;
      end
      LOAD: state_next = IDLE;
      RUN: begin
        if (press[BTN_LOAD])      state_next = LOAD;
        else if (press[BTN_RUN])  state_next = IDLE;
        else if (tick) begin
          // Stop at the terminal value rather than letting the counter wrap.
          if (terminal) state_next = DONE;
          else          en_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_reg == RUN && state_next == RUN)
      presc_next = tick ? '0 : presc_reg + 1'b1;
    else
      presc_next = '0;

    d_next = (state_next == LOAD) ? load_val : d_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      d_reg       <= '0;
      up_down_reg <= 1'b0;
      load_reg    <= 1'b0;
      en_reg      <= 1'b0;
      tc_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      d_reg       <= d_next;
      up_down_reg <= up_down_next;
      load_reg    <= (state_next == LOAD);
      en_reg      <= en_next;
      tc_reg      <= (state_next == DONE);
    end
  end

  assign load    = load_reg;
  assign d       = d_reg;
  assign up_down = up_down_reg;
  assign en      = en_reg;
  assign tc      = tc_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural model of the downstream
// 4-bit counter and a queue of expected results.
module tb_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;
  localparam int DEB   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             btn_load, btn_dir, btn_run;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             load, up_down, en, tc;
  logic [WIDTH-1:0] d;
  logic [1:0]       state;

  counter_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .DEB(DEB)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .btn_load(btn_load),
    .btn_dir (btn_dir),
    .btn_run (btn_run),
    .load_val(load_val),
    .count   (count),
    .load    (load),
    .d       (d),
    .up_down (up_down),
    .en      (en),
    .tc      (tc),
    .state   (state)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   en_times[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    q.push_back('{tag, v});
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance to the next falling edge, updating the downstream counter model
  // with the load/en values the DUT presented at the rising edge in between.
  task automatic cyc(input int n = 1);
    logic e, l, u;
    for (int i = 0; i < n; i++) begin
      e = en; l = load; u = up_down;
      if (e === 1'b1) en_times.push_back(cyc_n);
      @(negedge clk);
      cyc_n++;
      if (l === 1'b1) count = d;
      if (e === 1'b1) count = u ? count + 4'd1 : count - 4'd1;
    end
  endtask

  task automatic wait_change(input logic [1:0] from, input int budget, output int k);
    k = 0;
    while (state === from && k < budget) begin
      cyc();
      k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, c0, g;
    logic [31:0] flag;

    rst_n = 1'b0; btn_load = 0; btn_dir = 0; btn_run = 0;
    load_val = '0; count = '0;
    @(negedge clk);

    // Reset held while buttons toggle.
    flag = 0;
    for (int i = 0; i < 8; i++) begin
      btn_load = 1'($urandom); btn_dir = 1'($urandom); btn_run = 1'($urandom);
      cyc();
      flag = flag | {load, en, tc, up_down, state};
    end
    expect_v("rst_hold", 0); check("rst_hold", flag);
    btn_load = 0; btn_dir = 0; btn_run = 0;
    cyc();
    rst_n = 1'b1;
    cyc(2);
    expect_v("rst_release", 0); check("rst_release", {load, en, tc, up_down, state, d});
    cyc(DEB + 4);

    // Bounce rejection.
    flag = 0;
    btn_run = 1; cyc(); btn_run = 0; cyc(); btn_run = 1; cyc(); btn_run = 0; cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      flag = flag | 32'(state != S_IDLE);
    end
    expect_v("bounce_quiet", 0); check("bounce_quiet", flag);

    // Steady press: first sampling edge is the next rising edge.
    btn_run = 1;
    expect_v("run_latency", DEB + 3);
    wait_change(S_IDLE, 20, k);
    check("run_latency", k - 1);
    expect_v("run_state", S_RUN); check("run_state", state);
    btn_run = 0;
    en_times.delete();
    expect_v("done_at_zero", S_DONE);
    wait_change(S_RUN, 2 * DIV, k);
    check("done_at_zero", state);
    expect_v("tc_done", 1); check("tc_done", tc);
    expect_v("no_en_terminal", 0); check("no_en_terminal", en_times.size());
    cyc(DEB + 4);

    // Load from DONE.
    load_val = 4'hA;
    btn_load = 1;
    expect_v("load_state", S_LOAD);
    wait_change(S_DONE, 20, k);
    check("load_state", state);
    expect_v("load_pulse", 1); check("load_pulse", load);
    expect_v("load_d", 4'hA); check("load_d", d);
    load_val = 4'h5;
    cyc();
    expect_v("after_load", S_IDLE); check("after_load", state);
    expect_v("load_one_cycle", 0); check("load_one_cycle", load);
    expect_v("d_hold", 4'hA); check("d_hold", d);
    btn_load = 0;
    cyc(DEB + 4);

    // Simultaneous load and run presses: load wins, run is dropped.
    load_val = 4'h3;
    btn_load = 1; btn_run = 1;
    expect_v("prio_load", S_LOAD);
    wait_change(S_IDLE, 20, k);
    check("prio_load", state);
    expect_v("prio_d", 4'h3); check("prio_d", d);
    cyc(6);
    expect_v("prio_run_dropped", S_IDLE); check("prio_run_dropped", state);
    btn_load = 0; btn_run = 0;
    cyc(DEB + 4);

    // Down run from 3.
    btn_run = 1;
    expect_v("down_run", S_RUN);
    wait_change(S_IDLE, 20, k);
    check("down_run", state);
    btn_run = 0;
    c0 = cyc_n;
    en_times.delete();
    wait_change(S_RUN, 40, k);
    expect_v("down_en_count", 3); check("down_en_count", en_times.size());
    for (int i = 0; i < 3; i++) begin
      g = (en_times.size() > i) ? en_times[i] - ((i == 0) ? c0 : en_times[i-1]) : -1;
      expect_v("down_en_gap", DIV); check("down_en_gap", g);
    end
    expect_v("down_done", S_DONE); check("down_done", state);
    expect_v("down_tc", 1); check("down_tc", tc);
    expect_v("down_count_model", 0); check("down_count_model", count);
    cyc(DEB + 4);

    // Direction toggle in DONE, then up run from the terminal value.
    btn_dir = 1;
    cyc(DEB + 4);
    expect_v("dir_toggle", 1); check("dir_toggle", up_down);
    expect_v("dir_stays_done", S_DONE); check("dir_stays_done", state);
    btn_dir = 0;
    cyc(DEB + 4);
    count = 4'hF;
    btn_run = 1;
    expect_v("up_run", S_RUN);
    wait_change(S_DONE, 20, k);
    check("up_run", state);
    btn_run = 0;
    en_times.delete();
    expect_v("up_redone_cycles", DIV);
    wait_change(S_RUN, 2 * DIV + 2, k);
    check("up_redone_cycles", k);
    expect_v("up_redone", S_DONE); check("up_redone", state);
    expect_v("up_no_en", 0); check("up_no_en", en_times.size());
    expect_v("up_tc", 1); check("up_tc", tc);
    cyc(DEB + 4);

    // Reset while en is high.
    count = 4'h9;
    btn_run = 1;
    expect_v("mid_run", S_RUN);
    wait_change(S_DONE, 20, k);
    check("mid_run", state);
    btn_run = 0;
    k = 0;
    while (en !== 1'b1 && k < 2 * DIV + 2) begin
      cyc();
      k++;
    end
    expect_v("en_before_reset", 1); check("en_before_reset", en);
    rst_n = 1'b0;
    #1;
    expect_v("rst_en", 0); check("rst_en", en);
    expect_v("rst_state", S_IDLE); check("rst_state", state);
    expect_v("rst_up_down", 0); check("rst_up_down", up_down);
    cyc(2);
    rst_n = 1'b1;
    en_times.delete();
    cyc(3 * DIV);
    expect_v("no_en_after_reset", 0); check("no_en_after_reset", en_times.size());
    expect_v("idle_after_reset", S_IDLE); check("idle_after_reset", state);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
